tag_hop_scheduler: RTL and testbench

Sequences the frequency-hop schedule that drives the multi-tone tag-chip transmit datapath. On a start request it latches a transmit bit vector, aligns to a rising edge of the tag's DCO clock arriving on a front-panel GPIO pin, then steps through one hop per bit. For each hop it emits a phase increment, a hop index, a hop clock and a hop-reset pulse. It sits between the host register interface and the NCO/mixer chain of the main ANC transmit controller.

---
 rtl/tag_hop_scheduler.sv | 166 ++++++++++++++++
 tb/tb_tag_hop_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_hop_scheduler.sv
// Frequency-hop schedule sequencer: latches a bit vector, aligns to the DCO clock, emits one hop per bit.
// Optional pilot hop before data hop 0 when TAG_HOP_PILOT_EN is defined.
module tag_hop_scheduler #(
    parameter int PHASE_WIDTH   = 24,
    parameter int TX_BITS_WIDTH = 128,
    parameter int BIT_CNT_WIDTH = 7,
    parameter int HOP_LEN       = 8192,
    parameter int BASE_PH_INC   = 4096,
    parameter int HOP_STEP      = 256,
    parameter int BIT_OFFSET    = 128,
    parameter int PILOT_PH_INC  = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [TX_BITS_WIDTH-1:0] tx_bits,
    input  logic [BIT_CNT_WIDTH-1:0] ntx_bits,
    input  logic                     dco_clk_in,
    output logic [PHASE_WIDTH-1:0]   hop_ph_inc,
    output logic [BIT_CNT_WIDTH-1:0] nhop,
    output logic                     hop_clk,
    output logic                     hop_rst,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(HOP_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HOP_LEN / 2);
`ifdef TAG_HOP_PILOT_EN
    localparam bit PILOT_EN = 1'b1;
`else
    localparam bit PILOT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, HOP, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_CNT_WIDTH-1:0] idx_q, idx_d;
    logic                     pilot_q, pilot_d;
    logic                     latch_en;
    logic [TX_BITS_WIDTH-1:0] tx_q;
    logic [BIT_CNT_WIDTH-1:0] ntx_q;
    logic [2:0]               dco_sync;
    logic                     dco_edge;
    logic [PHASE_WIDTH-1:0]   ph_d;

    // Two synchronizer flops, one history flop, registered rising-edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            dco_sync <= '0;
            dco_edge <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            dco_sync <= {dco_sync[1:0], dco_clk_in};
            dco_edge <= dco_sync[1] & ~dco_sync[2];
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pilot_d  = pilot_q;
        latch_en = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            pilot_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    pilot_d = 1'b0;
                    if (start) begin
                        latch_en = 1'b1;
                        state_d  = (ntx_bits == '0 && !PILOT_EN) ? DONE : WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    if (dco_edge) begin
                        state_d = HOP;
                        cnt_d   = '0;
                        idx_d   = '0;
                        pilot_d = PILOT_EN;
                    end
                end
                HOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (pilot_q) begin
                            pilot_d = 1'b0;
                            if (ntx_q == '0) state_d = DONE;
                        end else if (idx_q == ntx_q - BIT_CNT_WIDTH'(1)) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + BIT_CNT_WIDTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Phase for the hop that starts next cycle; wraps modulo 2^PHASE_WIDTH.
    always_comb begin
        ph_d = PHASE_WIDTH'(BASE_PH_INC) + PHASE_WIDTH'(idx_d) * PHASE_WIDTH'(HOP_STEP)
             + (tx_q[idx_d] ? PHASE_WIDTH'(BIT_OFFSET) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pilot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pilot_q <= pilot_d;
        end
    end

    // NOTE: latched payload needs no reset; it is only read after an accepted start.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            tx_q  <= tx_bits;
            ntx_q <= ntx_bits;
        end
    end

    // Outputs registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            hop_ph_inc <= '0;
            nhop       <= '0;
            hop_clk    <= 1'b0;
            hop_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            hop_rst <= (state_d == HOP) && (cnt_d == '0);
            hop_clk <= (state_d == HOP) && (cnt_d < CNT_HALF);
            nhop    <= (state_d == HOP) ? idx_d : '0;
            if (state_d != HOP)
                hop_ph_inc <= '0;
            else if (pilot_d)
                hop_ph_inc <= PHASE_WIDTH'(PILOT_PH_INC);
            else
                hop_ph_inc <= ph_d;
        end
    end

endmodule

// File: tb/tb_tag_hop_scheduler.sv
// Directed bench for tag_hop_scheduler with HOP_LEN = 8; a second instance checks phase wrap-around.
module tb_tag_hop_scheduler;

    localparam int HL = 8;
`ifdef TAG_HOP_PILOT_EN
    localparam int PIL = HL;
`else
    localparam int PIL = 0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, abort, dco;
    logic [127:0] tx_bits;
    logic [6:0]   ntx_bits;
    logic [23:0]  ph, w_ph;
    logic [6:0]   nhop, w_nhop;
    logic         hop_clk, hop_rst, busy, done;
    logic         w_hop_clk, w_hop_rst, w_busy, w_done;

    int tests = 0;
    int failed = 0;

    tag_hop_scheduler #(.HOP_LEN(HL)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .tx_bits(tx_bits), .ntx_bits(ntx_bits), .dco_clk_in(dco),
        .hop_ph_inc(ph), .nhop(nhop), .hop_clk(hop_clk), .hop_rst(hop_rst),
        .busy(busy), .done(done)
    );

    tag_hop_scheduler #(.HOP_LEN(HL), .BASE_PH_INC((1 << 24) - 64)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .tx_bits(tx_bits), .ntx_bits(ntx_bits), .dco_clk_in(dco),
        .hop_ph_inc(w_ph), .nhop(w_nhop), .hop_clk(w_hop_clk), .hop_rst(w_hop_rst),
        .busy(w_busy), .done(w_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ticks until hop_rst is seen; n is the number of ticks taken (40 means timeout).
    task automatic wait_first_hop(output int n);
        n = 0;
        while (hop_rst !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; dco = 1'b0;
        tx_bits = '0; ntx_bits = '0;
        tick();
        tick();
        reset = 1'b0;
        tests++; if ({ph, nhop} !== '0) begin failed++; $display("FAIL reset_ph_nhop: got %0d/%0d expected 0/0", ph, nhop); end
        tests++; if (hop_clk !== 1'b0) begin failed++; $display("FAIL reset_hop_clk: got %b expected 0", hop_clk); end
        tests++; if (hop_rst !== 1'b0) begin failed++; $display("FAIL reset_hop_rst: got %b expected 0", hop_rst); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_basic;
        int          n, rst_cnt, h, c;
        logic [23:0] e_ph;
        int          exp_ph [3] = '{4224, 4352, 4736};
        tx_bits = 128'b101; ntx_bits = 7'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL basic_no_early_done: got %b expected 0", done); end
        repeat (9) tick();
        dco = 1'b1;
        wait_first_hop(n);
        tests++; if (n != 4) begin failed++; $display("FAIL sync_latency: got %0d cycles expected 4", n); end
        rst_cnt = 0;
        for (int i = 0; i < PIL + 3 * HL; i++) begin
            c = i % HL;
            h = (i < PIL) ? 0 : (i - PIL) / HL;
            e_ph = (i < PIL) ? 24'd4096 : 24'(exp_ph[h]);
            tests++; if (ph !== e_ph) begin failed++; $display("FAIL basic_ph[%0d]: got %0d expected %0d", i, ph, e_ph); end
            tests++; if (nhop !== 7'(h)) begin failed++; $display("FAIL basic_nhop[%0d]: got %0d expected %0d", i, nhop, h); end
            tests++; if (hop_rst !== (c == 0)) begin failed++; $display("FAIL basic_hop_rst[%0d]: got %b expected %b", i, hop_rst, c == 0); end
            tests++; if (hop_clk !== (c < HL / 2)) begin failed++; $display("FAIL basic_hop_clk[%0d]: got %b expected %b", i, hop_clk, c < HL / 2); end
            tests++; if ({busy, done} !== 2'b10) begin failed++; $display("FAIL basic_busy_done[%0d]: got %b expected 10", i, {busy, done}); end
            if (i == PIL) begin
                tests++; if (w_ph !== 24'd64) begin failed++; $display("FAIL wrap_hop0: got %0d expected 64", w_ph); end
            end
            if (i == PIL + 2 * HL) begin
                tests++; if (w_ph !== 24'd576) begin failed++; $display("FAIL wrap_hop2: got %0d expected 576", w_ph); end
            end
            if (hop_rst === 1'b1) rst_cnt++;
            tick();
        end
        tests++; if ({busy, done} !== 2'b11) begin failed++; $display("FAIL basic_done_pulse: got %b expected 11", {busy, done}); end
        tests++; if (rst_cnt != 3 + PIL / HL) begin failed++; $display("FAIL basic_rst_count: got %0d expected %0d", rst_cnt, 3 + PIL / HL); end
        tick();
        tests++; if ({busy, done} !== 2'b00) begin failed++; $display("FAIL basic_idle_after: got %b expected 00", {busy, done}); end
        tests++; if (ph !== 24'd0) begin failed++; $display("FAIL basic_idle_ph: got %0d expected 0", ph); end
        dco = 1'b0;
        repeat (3) tick();
    endtask

`ifndef TAG_HOP_PILOT_EN
    task automatic test_zero_bits;
        int rst_seen;
        ntx_bits = 7'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if ({busy, done, hop_rst} !== 3'b110) begin failed++; $display("FAIL zero_done: got %b expected 110", {busy, done, hop_rst}); end
        tick();
        tests++; if ({busy, done} !== 2'b00) begin failed++; $display("FAIL zero_busy_fall: got %b expected 00", {busy, done}); end
        rst_seen = 0;
        repeat (10) begin
            if (hop_rst === 1'b1 || busy === 1'b1) rst_seen++;
            tick();
        end
        tests++; if (rst_seen != 0) begin failed++; $display("FAIL zero_no_hop: got %0d active cycles expected 0", rst_seen); end
    endtask
`else
    task automatic test_pilot_zero_bits;
        int n;
        ntx_bits = 7'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if ({busy, done} !== 2'b10) begin failed++; $display("FAIL pzero_wait: got %b expected 10", {busy, done}); end
        dco = 1'b1;
        wait_first_hop(n);
        tests++; if (n != 4) begin failed++; $display("FAIL pzero_sync: got %0d cycles expected 4", n); end
        tests++; if (ph !== 24'd4096) begin failed++; $display("FAIL pzero_ph: got %0d expected 4096", ph); end
        repeat (HL) tick();
        tests++; if ({busy, done, hop_rst} !== 3'b110) begin failed++; $display("FAIL pzero_done: got %b expected 110", {busy, done, hop_rst}); end
        tick();
        dco = 1'b0;
        repeat (3) tick();
    endtask
`endif

    task automatic test_abort_and_ignored_start;
        int n, k, done_seen;
        tx_bits = 128'b101; ntx_bits = 7'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        dco = 1'b1;
        wait_first_hop(n);
        tests++; if (n != 4) begin failed++; $display("FAIL abort_sync: got %0d cycles expected 4", n); end
        tick();
        tick();
        tx_bits = 128'b010; ntx_bits = 7'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if ({busy, hop_rst} !== 2'b10) begin failed++; $display("FAIL ignored_start: got %b expected 10", {busy, hop_rst}); end
        k = 0;
        while (nhop !== 7'd1 && k < 40) begin
            tick();
            k++;
        end
        tests++; if (hop_rst !== 1'b1) begin failed++; $display("FAIL abort_hop1_start: got %b expected 1", hop_rst); end
        tests++; if (ph !== 24'd4352) begin failed++; $display("FAIL latched_bits: got %0d expected 4352", ph); end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if ({ph, nhop} !== '0) begin failed++; $display("FAIL abort_ph_nhop: got %0d/%0d expected 0/0", ph, nhop); end
        tests++; if ({hop_clk, hop_rst, busy, done} !== 4'b0) begin failed++; $display("FAIL abort_flags: got %b expected 0000", {hop_clk, hop_rst, busy, done}); end
        done_seen = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        tests++; if (done_seen != 0) begin failed++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen); end
        dco = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_abort_priority;
        int rst_seen;
        tx_bits = 128'b1; ntx_bits = 7'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL abort_over_start: got %b expected 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        dco = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if ({busy, hop_rst} !== 2'b00) begin failed++; $display("FAIL abort_over_edge: got %b expected 00", {busy, hop_rst}); end
        rst_seen = 0;
        repeat (20) begin
            if (hop_rst === 1'b1 || done === 1'b1) rst_seen++;
            tick();
        end
        tests++; if (rst_seen != 0) begin failed++; $display("FAIL abort_edge_quiet: got %0d active cycles expected 0", rst_seen); end
        dco = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_hop;
        int n, done_seen;
        tx_bits = 128'b11; ntx_bits = 7'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        dco = 1'b1;
        wait_first_hop(n);
        tests++; if (n != 4) begin failed++; $display("FAIL rstmid_sync: got %0d cycles expected 4", n); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if ({ph, nhop} !== '0) begin failed++; $display("FAIL rstmid_ph_nhop: got %0d/%0d expected 0/0", ph, nhop); end
        tests++; if ({hop_clk, hop_rst, busy, done} !== 4'b0) begin failed++; $display("FAIL rstmid_flags: got %b expected 0000", {hop_clk, hop_rst, busy, done}); end
        done_seen = 0;
        repeat (30) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        tests++; if (done_seen != 0) begin failed++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_seen); end
        dco = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
`ifndef TAG_HOP_PILOT_EN
        test_zero_bits();
`else
        test_pilot_zero_bits();
`endif
        test_abort_and_ignored_start();
        test_abort_priority();
        test_reset_mid_hop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
